// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and execute-stage operand selector for the 32-bit ALU.
// Handles EX/MEM and MEM/WB forwarding, load-use stalls, flush bubbles and opcode sanitising.
module ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [OP_W-1:0]  id_op,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [WIDTH-1:0] id_rs1_data,
    input  logic [WIDTH-1:0] id_rs2_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_use_imm,
    input  logic             id_uses_rs2,
    input  logic             id_is_load,
    input  logic             id_reg_write,
    input  logic             flush,
    input  logic             exmem_reg_write,
    input  logic [RA_W-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RA_W-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic             stall,
    output logic             ex_valid,
    output logic [OP_W-1:0]  ex_op,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [RA_W-1:0]  ex_rd,
    output logic             ex_reg_write,
    output logic             ex_is_load,
    output logic             ex_illegal
);

    logic             valid_q, valid_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [RA_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [WIDTH-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic             use_imm_q, use_imm_d;
    logic             is_load_q, is_load_d;
    logic             reg_write_q, reg_write_d;
    logic             illegal_q, illegal_d;

    logic             op_legal;
    logic             bad_op;
    logic [WIDTH-1:0] fwd_rs1, fwd_rs2;

    always_comb begin
        op_legal = (id_op == OP_W'(5'b00000)) || (id_op == OP_W'(5'b00001)) ||
                   (id_op == OP_W'(5'b00010)) || (id_op == OP_W'(5'b00100)) ||
                   (id_op == OP_W'(5'b00101)) || (id_op == OP_W'(5'b00110));
        bad_op   = id_valid & ~op_legal;
    end

    // Load-use hazard: the load in EX has no result yet for the instruction in ID.
    always_comb begin
        stall = id_valid & valid_q & is_load_q & (rd_q != '0) &
                ((rd_q == id_rs1) | (id_uses_rs2 & ~id_use_imm & (rd_q == id_rs2)));
    end

    always_comb begin
        valid_d     = 1'b0;
        op_d        = '0;
        rs1_d       = '0;
        rs2_d       = '0;
        rd_d        = '0;
        rs1_data_d  = '0;
        rs2_data_d  = '0;
        imm_d       = '0;
        use_imm_d   = 1'b0;
        is_load_d   = 1'b0;
        reg_write_d = 1'b0;
        illegal_d   = 1'b0;
        if (!flush && !stall) begin
            valid_d     = id_valid;
            // Unimplemented ops never reach the ALU, even in invalid slots.
            op_d        = op_legal ? id_op : '0;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            is_load_d   = id_is_load;
            reg_write_d = id_reg_write & ~bad_op;
            illegal_d   = bad_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            op_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            is_load_q   <= 1'b0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            is_load_q   <= is_load_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

    // The nearer producer (EX/MEM) wins; register 0 is hard-wired and never forwarded.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (rs1_q != '0 && exmem_reg_write && exmem_rd == rs1_q)
            fwd_rs1 = exmem_result;
        else if (rs1_q != '0 && memwb_reg_write && memwb_rd == rs1_q)
            fwd_rs1 = memwb_result;

        fwd_rs2 = rs2_data_q;
        if (rs2_q != '0 && exmem_reg_write && exmem_rd == rs2_q)
            fwd_rs2 = exmem_result;
        else if (rs2_q != '0 && memwb_reg_write && memwb_rd == rs2_q)
            fwd_rs2 = memwb_result;
    end

    always_comb begin
        ex_valid     = valid_q;
        ex_op        = op_q;
        ex_rd        = rd_q;
        ex_reg_write = reg_write_q;
        ex_is_load   = is_load_q;
        ex_illegal   = illegal_q;
        ex_a         = valid_q ? fwd_rs1 : '0;
        ex_b         = valid_q ? (use_imm_q ? imm_q : fwd_rs2) : '0;
    end

endmodule
